// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and line-level constants for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Even parity bit: makes the total count of ones in data+parity even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts clocks within one serial bit and ticks on the last one
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Tick fires during the final clock of each bit while a frame is running.
    assign bit_end = run && (cnt == LAST);

    // Counter held at zero while idle so every frame starts on a fresh bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter top (define UART_TX_PARITY_EN for 8E1 frames)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_bit,
    input  logic [7:0] extern_data,
    output logic       out,
    output logic       o_active,
    output logic       o_done
);

    state_t                 state, state_nxt;
    logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
    logic [2:0]             bit_idx, bit_idx_nxt;
    logic                   bit_end;
    logic                   timer_run;
    logic                   out_nxt, active_nxt, done_nxt;

    assign timer_run = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (timer_run),
        .bit_end (bit_end)
    );

    // State, datapath and registered outputs; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            out       <= IDLE_LEVEL;
            o_active  <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            out       <= out_nxt;
            o_active  <= active_nxt;
            o_done    <= done_nxt;
        end
    end

    // Next state: requests are only honoured from IDLE, bits advance on timer ticks.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        unique case (state)
            IDLE: begin
                if (start_bit) begin
                    state_nxt   = START;
                    shift_nxt   = extern_data;
                    bit_idx_nxt = '0;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from the upcoming state so the registered line changes only at bit boundaries.
    always_comb begin
        out_nxt    = IDLE_LEVEL;
        active_nxt = (state_nxt != IDLE);
        done_nxt   = (state == STOP) && bit_end;
        unique case (state_nxt)
            START:   out_nxt = START_LEVEL;
            DATA:    out_nxt = shift_nxt[bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_nxt = even_parity(shift_nxt);
`endif
            STOP:    out_nxt = STOP_LEVEL;
            default: out_nxt = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (honours UART_TX_PARITY_EN)
module tb_uart_tx;

    localparam int C = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_bit = 1'b0;
    logic [7:0] extern_data = 8'h00;
    logic       out, o_active, o_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_bit   (start_bit),
        .extern_data (extern_data),
        .out         (out),
        .o_active    (o_active),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a list of bit levels played out for C cycles each, timed from acceptance.
    logic          e_out = 1'b1, e_act = 1'b0, e_done = 1'b0;
    logic          m_busy = 1'b0;
    int            m_t = 0;
    logic [NB-1:0] m_frame = '1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_t    = 0;
                e_out  = 1'b1;
                e_act  = 1'b0;
                e_done = 1'b0;
            end else begin
                e_done = 1'b0;
                if (!m_busy) begin
                    if (start_bit) begin
                        m_busy = 1'b1;
                        m_t    = 0;
`ifdef UART_TX_PARITY_EN
                        m_frame = {1'b1, ^extern_data, extern_data, 1'b0};
`else
                        m_frame = {1'b1, extern_data, 1'b0};
`endif
                    end
                end else begin
                    m_t++;
                    if (m_t == FRAME) begin
                        m_busy = 1'b0;
                        e_done = 1'b1;
                    end
                end
                e_act = m_busy;
                e_out = m_busy ? m_frame[m_t / C] : 1'b1;
            end
        end
    end

    // Every cycle, outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_out", 32'(out), 32'(e_out));
            chk("model_active", 32'(o_active), 32'(e_act));
            chk("model_done", 32'(o_done), 32'(e_done));
        end
    end

    // Advance n cycles (negedge to negedge), counting done pulses and active cycles.
    task automatic run_cycles(input int n, output int dones, output int acts);
        dones = 0;
        acts  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) dones++;
            if (o_active === 1'b1) acts++;
        end
    endtask

    logic [NB-1:0] lit;
    int dn, ac;

    initial begin
`ifdef UART_TX_PARITY_EN
        lit = 11'b11101110100;
`else
        lit = 10'b1101110100;
`endif
        #1 rst_n = 1'b0;
        start_bit   = 1'b1;
        extern_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_out", 32'(out), 32'h1);
            chk("reset_active", 32'(o_active), 32'h0);
            chk("reset_done", 32'(o_done), 32'h0);
        end
        start_bit = 1'b0;
        #2 rst_n = 1'b1;
        run_cycles(2, dn, ac);

        // Basic frame, checked against hand-written levels.
        extern_data = 8'hBA;
        start_bit   = 1'b1;
        @(negedge clk);
        start_bit   = 1'b0;
        extern_data = 8'h00;
        ac = 0;
        for (int i = 0; i < FRAME; i++) begin
            chk("basic_level", 32'(out), 32'(lit[i / C]));
            if (o_active === 1'b1) ac++;
            @(negedge clk);
        end
        chk("basic_active_cycles", 32'(ac), 32'(FRAME));
        chk("basic_done", 32'(o_done), 32'h1);
        chk("basic_done_active", 32'(o_active), 32'h0);
        @(negedge clk);
        chk("basic_done_pulse", 32'(o_done), 32'h0);
        run_cycles(3, dn, ac);

        // Busy ignore: second request mid-frame is dropped.
        extern_data = 8'h3C;
        start_bit   = 1'b1;
        @(negedge clk);
        start_bit = 1'b0;
        run_cycles(7, dn, ac);
        extern_data = 8'h55;
        start_bit   = 1'b1;
        @(negedge clk);
        start_bit = 1'b0;
        run_cycles(FRAME + 10, dn, ac);
        chk("busy_done_count", 32'(dn), 32'h1);

        // Back-to-back frames with start held high.
        extern_data = 8'hA5;
        start_bit   = 1'b1;
        run_cycles(FRAME + 4, dn, ac);
        start_bit = 1'b0;
        run_cycles(FRAME + 4, dn, ac);
        chk("b2b_second_done", 32'(dn), 32'h1);
        run_cycles(5, dn, ac);
        chk("b2b_no_third", 32'(ac), 32'h0);

        // Reset during data bit 3.
        extern_data = 8'hC3;
        start_bit   = 1'b1;
        @(negedge clk);
        start_bit = 1'b0;
        run_cycles(4 * C, dn, ac);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(out), 32'h1);
        chk("midrst_active", 32'(o_active), 32'h0);
        chk("midrst_done", 32'(o_done), 32'h0);
        run_cycles(2, dn, ac);
        #2 rst_n = 1'b1;
        run_cycles(FRAME, dn, ac);
        chk("midrst_no_done", 32'(dn), 32'h0);
        extern_data = 8'h81;
        start_bit   = 1'b1;
        @(negedge clk);
        start_bit = 1'b0;
        run_cycles(FRAME + 3, dn, ac);
        chk("after_rst_done", 32'(dn), 32'h1);
        chk("after_rst_active", 32'(ac), 32'(FRAME - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
